// File: rtl/nec_ir_pkg.sv
// Shared types and timing limits for the NEC IR receiver.
// All widths are in microseconds of the 1 us tick.
package nec_ir_pkg;

   localparam int unsigned SEG_W     = 14;
   localparam int unsigned WIN_W     = 17;
   localparam int unsigned SEG_MAX   = 16383;
   localparam int unsigned T_TIMEOUT = 12000;

   localparam int unsigned T_LEAD_MARK_MIN  = 8000;
   localparam int unsigned T_LEAD_MARK_MAX  = 10000;
   localparam int unsigned T_LEAD_SPACE_MIN = 4000;
   localparam int unsigned T_LEAD_SPACE_MAX = 5000;
   localparam int unsigned T_RPT_SPACE_MIN  = 2000;
   localparam int unsigned T_RPT_SPACE_MAX  = 2500;
   localparam int unsigned T_MARK_MIN       = 400;
   localparam int unsigned T_MARK_MAX       = 700;
   localparam int unsigned T_ZERO_MIN       = 400;
   localparam int unsigned T_ZERO_MAX       = 700;
   localparam int unsigned T_ONE_MIN        = 1400;
   localparam int unsigned T_ONE_MAX        = 1900;

   localparam logic [7:0] KEY_RESET_DEF  = 8'h0C;
   localparam logic [7:0] KEY_LEFT_DEF   = 8'h0E;
   localparam logic [7:0] KEY_RIGHT_DEF  = 8'h12;
   localparam logic [7:0] KEY_SELECT_DEF = 8'h11;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LEAD_MARK,
      S_LEAD_SPACE,
      S_BIT_MARK,
      S_BIT_SPACE,
      S_STOP_MARK,
      S_CHECK,
      S_RPT_STOP,
      S_RPT_CHECK
   } state_t;

   function automatic logic in_range(input logic [SEG_W-1:0] v,
                                     input int unsigned lo,
                                     input int unsigned hi);
      return (32'(v) >= lo) && (32'(v) <= hi);
   endfunction

endpackage

// File: rtl/ir_us_tick.sv
// Prescaler producing a single-cycle tick every TICK_DIV clocks (1 us).
module ir_us_tick #(
   parameter int unsigned TICK_DIV = 50
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned      CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= (cnt == LAST);
         if (cnt == LAST) cnt <= '0;
         else             cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/nec_ir_decoder.sv
// NEC IR receiver: measures mark/space widths of the demodulated input, decodes
// frames and repeat codes, and pulses the menu button lines.
module nec_ir_decoder
   import nec_ir_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter bit          ADDR_CHECK = 1'b0,
   parameter logic [7:0]  ADDR       = 8'h00,
   parameter bit          REPEAT_EN  = 1'b1,
   parameter int unsigned REPEAT_WIN = 120_000,
   parameter int unsigned PULSE_CYC  = 2,
   parameter logic [7:0]  KEY_RESET  = KEY_RESET_DEF,
   parameter logic [7:0]  KEY_LEFT   = KEY_LEFT_DEF,
   parameter logic [7:0]  KEY_RIGHT  = KEY_RIGHT_DEF,
   parameter logic [7:0]  KEY_SELECT = KEY_SELECT_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       E,
   output logic [7:0] key,
   output logic [7:0] addr,
   output logic       valid,
   output logic       rpt,
   output logic       err,
   output logic       w1,
   output logic       w2,
   output logic       w3,
   output logic       w4
);

   localparam int unsigned      TICK_DIV = CLK_HZ / 1_000_000;
   localparam int unsigned      HOLD_W   = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(REPEAT_WIN - 1);

   logic              tick;
   logic              e_s1, e_s2, e_d;
   logic              fall_c, rise_c;
   logic [SEG_W-1:0]  seg_us;
   state_t            state;
   logic [4:0]        bit_cnt;
   logic [31:0]       shift;
   logic [WIN_W-1:0]  win_cnt;
   logic              win_open;
   logic [HOLD_W-1:0] hold;

   logic timeout_c, lead_mark_ok_c, lead_space_ok_c, rpt_space_ok_c;
   logic mark_ok_c, zero_ok_c, one_ok_c, accept_c, abort_c;
   logic btn_ev_c, btn_map_c;
   logic [7:0] btn_key_c;

   ir_us_tick #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .tick  (tick)
   );

   assign fall_c = e_d & ~e_s2;
   assign rise_c = ~e_d & e_s2;

   assign timeout_c       = 32'(seg_us) >= T_TIMEOUT;
   assign lead_mark_ok_c  = in_range(seg_us, T_LEAD_MARK_MIN, T_LEAD_MARK_MAX);
   assign lead_space_ok_c = in_range(seg_us, T_LEAD_SPACE_MIN, T_LEAD_SPACE_MAX);
   assign rpt_space_ok_c  = in_range(seg_us, T_RPT_SPACE_MIN, T_RPT_SPACE_MAX);
   assign mark_ok_c       = in_range(seg_us, T_MARK_MIN, T_MARK_MAX);
   assign zero_ok_c       = in_range(seg_us, T_ZERO_MIN, T_ZERO_MAX);
   assign one_ok_c        = in_range(seg_us, T_ONE_MIN, T_ONE_MAX);

   assign accept_c = (shift[31:24] == ~shift[23:16]) && (shift[15:8] == ~shift[7:0]) &&
                     (!ADDR_CHECK || (shift[7:0] == ADDR));

   // Malformed segment inside a frame: drop to IDLE and flag it.
   always_comb begin
      abort_c = 1'b0;
      case (state)
         S_LEAD_MARK:  abort_c = timeout_c;
         S_LEAD_SPACE: abort_c = timeout_c || (fall_c && !lead_space_ok_c && !rpt_space_ok_c);
         S_BIT_MARK,
         S_STOP_MARK,
         S_RPT_STOP:   abort_c = timeout_c || (rise_c && !mark_ok_c);
         S_BIT_SPACE:  abort_c = timeout_c || (fall_c && !zero_ok_c && !one_ok_c);
         default:      abort_c = 1'b0;
      endcase
   end

   always_comb begin
      btn_ev_c  = 1'b0;
      btn_key_c = key;
      if (state == S_CHECK && accept_c) begin
         btn_ev_c  = 1'b1;
         btn_key_c = shift[23:16];
      end else if (state == S_RPT_CHECK && REPEAT_EN && win_open) begin
         btn_ev_c  = 1'b1;
      end
      btn_map_c = (btn_key_c == KEY_RESET) || (btn_key_c == KEY_LEFT) ||
                  (btn_key_c == KEY_RIGHT) || (btn_key_c == KEY_SELECT);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         e_s1     <= 1'b1;
         e_s2     <= 1'b1;
         e_d      <= 1'b1;
         seg_us   <= '0;
         state    <= S_IDLE;
         bit_cnt  <= '0;
         shift    <= '0;
         win_cnt  <= '0;
         win_open <= 1'b0;
         key      <= '0;
         addr     <= '0;
         valid    <= 1'b0;
         rpt      <= 1'b0;
         err      <= 1'b0;
      end else begin
         e_s1  <= E;
         e_s2  <= e_s1;
         e_d   <= e_s2;
         valid <= 1'b0;
         rpt   <= 1'b0;
         err   <= 1'b0;

         if (fall_c || rise_c)
            seg_us <= '0;
         else if (tick && seg_us != SEG_W'(SEG_MAX))
            seg_us <= seg_us + SEG_W'(1);

         if (win_open && tick) begin
            if (win_cnt == WIN_LAST) win_open <= 1'b0;
            else                     win_cnt  <= win_cnt + WIN_W'(1);
         end

         if (abort_c) begin
            state    <= S_IDLE;
            err      <= 1'b1;
            win_open <= 1'b0;
         end else begin
            case (state)
               S_IDLE:       if (fall_c) state <= S_LEAD_MARK;
               // Short or long leader marks are treated as noise, not errors.
               S_LEAD_MARK:  if (rise_c) state <= lead_mark_ok_c ? S_LEAD_SPACE : S_IDLE;
               S_LEAD_SPACE: if (fall_c) begin
                  bit_cnt <= '0;
                  state   <= lead_space_ok_c ? S_BIT_MARK : S_RPT_STOP;
               end
               S_BIT_MARK:   if (rise_c) state <= S_BIT_SPACE;
               S_BIT_SPACE:  if (fall_c) begin
                  shift   <= {one_ok_c, shift[31:1]};
                  bit_cnt <= bit_cnt + 5'd1;
                  state   <= (bit_cnt == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
               end
               S_STOP_MARK:  if (rise_c) state <= S_CHECK;
               S_CHECK: begin
                  state <= S_IDLE;
                  if (accept_c) begin
                     valid    <= 1'b1;
                     key      <= shift[23:16];
                     addr     <= shift[7:0];
                     win_cnt  <= '0;
                     win_open <= 1'b1;
                  end else begin
                     err      <= 1'b1;
                     win_open <= 1'b0;
                  end
               end
               S_RPT_STOP:   if (rise_c) state <= S_RPT_CHECK;
               S_RPT_CHECK: begin
                  state <= S_IDLE;
                  if (REPEAT_EN) begin
                     if (win_open) begin
                        rpt      <= 1'b1;
                        win_cnt  <= '0;
                        win_open <= 1'b1;
                     end else begin
                        err <= 1'b1;
                     end
                  end
               end
               default:      state <= S_IDLE;
            endcase
         end
      end
   end

   // Button lines: asserted from the event cycle for PULSE_CYC cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         hold <= '0;
         w1   <= 1'b1;
         w2   <= 1'b1;
         w3   <= 1'b1;
         w4   <= 1'b0;
      end else if (btn_ev_c && btn_map_c) begin
         hold <= HOLD_W'(PULSE_CYC - 1);
         w1   <= (btn_key_c != KEY_LEFT);
         w2   <= (btn_key_c != KEY_RIGHT);
         w3   <= (btn_key_c != KEY_SELECT);
         w4   <= (btn_key_c == KEY_RESET);
      end else if (hold != '0) begin
         hold <= hold - HOLD_W'(1);
      end else begin
         w1 <= 1'b1;
         w2 <= 1'b1;
         w3 <= 1'b1;
         w4 <= 1'b0;
      end
   end

endmodule

// File: tb/tb_nec_ir_decoder.sv
// Directed bench for nec_ir_decoder at 2 MHz (2 clocks per us), nominal NEC widths.
module tb_nec_ir_decoder;

   logic       clk = 1'b0;
   logic       reset;
   logic       E;
   logic [7:0] key, addr, key2, addr2;
   logic       valid, rpt, err, w1, w2, w3, w4;
   logic       valid2, rpt2, err2, w1b, w2b, w3b, w4b;

   always #5 clk = ~clk;

   nec_ir_decoder #(.CLK_HZ(2_000_000)) dut (
      .clk(clk), .reset(reset), .E(E), .key(key), .addr(addr),
      .valid(valid), .rpt(rpt), .err(err), .w1(w1), .w2(w2), .w3(w3), .w4(w4)
   );

   nec_ir_decoder #(.CLK_HZ(2_000_000), .ADDR_CHECK(1'b1), .ADDR(8'h5A)) dut2 (
      .clk(clk), .reset(reset), .E(E), .key(key2), .addr(addr2),
      .valid(valid2), .rpt(rpt2), .err(err2), .w1(w1b), .w2(w2b), .w3(w3b), .w4(w4b)
   );

   typedef struct {
      bit         is_rpt;
      int         gap_us;
      logic [7:0] a, c, nc;
      int         e_valid, e_rpt, e_err;
      logic [7:0] e_key, e_addr;
      int         e_w1, e_w2, e_w3, e_w4;
      int         e_valid2, e_err2;
   } vec_t;

   vec_t vecs[6];

   int n_pass = 0, n_total = 0;
   int cyc = 0, rise_cyc = 0, last_ev = -1;
   int n_valid, n_rpt, n_err, n_valid2, n_err2, c_w1, c_w2, c_w3, c_w4;
   int n_excl = 0, n_rpt2 = 0, c_btn2 = 0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (valid)  n_valid++;
      if (rpt)    n_rpt++;
      if (err)    n_err++;
      if (valid2) n_valid2++;
      if (err2)   n_err2++;
      if (rpt2)   n_rpt2++;
      if (valid || rpt || err) last_ev = cyc;
      if (int'(valid) + int'(rpt) + int'(err) > 1) n_excl++;
      if (!w1) c_w1++;
      if (!w2) c_w2++;
      if (!w3) c_w3++;
      if (w4)  c_w4++;
      if (!w1b || !w2b || !w3b || w4b) c_btn2++;
   end

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic clear_counts();
      n_valid = 0; n_rpt = 0; n_err = 0; n_valid2 = 0; n_err2 = 0;
      c_w1 = 0; c_w2 = 0; c_w3 = 0; c_w4 = 0; last_ev = -1;
   endtask

   task automatic hold_us(input logic lvl, input int us);
      E = lvl;
      repeat (2 * us) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [31:0] d, input int rst_bit);
      hold_us(1'b0, 9000);
      hold_us(1'b1, 4500);
      for (int i = 0; i < 32; i++) begin
         if (i == rst_bit) begin
            reset = 1'b1;
            @(posedge clk);
            #1 reset = 1'b0;
         end
         hold_us(1'b0, 560);
         hold_us(1'b1, d[i] ? 1690 : 560);
      end
      hold_us(1'b0, 560);
      E = 1'b1;
      rise_cyc = cyc;
   endtask

   task automatic send_repeat();
      hold_us(1'b0, 9000);
      hold_us(1'b1, 2250);
      hold_us(1'b0, 560);
      E = 1'b1;
      rise_cyc = cyc;
   endtask

   initial begin
      reset = 1'b1;
      E     = 1'b1;
      vecs[0] = '{1'b0, 15000,  8'h00, 8'h0C, 8'hF3, 1, 0, 0, 8'h0C, 8'h00, 0, 0, 0, 2, 0, 1};
      vecs[1] = '{1'b0, 15000,  8'h00, 8'h0E, 8'hF1, 1, 0, 0, 8'h0E, 8'h00, 2, 0, 0, 0, 0, 1};
      vecs[2] = '{1'b1, 40000,  8'h00, 8'h00, 8'h00, 0, 1, 0, 8'h0E, 8'h00, 2, 0, 0, 0, 0, 1};
      vecs[3] = '{1'b1, 130000, 8'h00, 8'h00, 8'h00, 0, 0, 1, 8'h0E, 8'h00, 0, 0, 0, 0, 0, 1};
      vecs[4] = '{1'b0, 15000,  8'h00, 8'h12, 8'h00, 0, 0, 1, 8'h0E, 8'h00, 0, 0, 0, 0, 0, 1};
      vecs[5] = '{1'b0, 15000,  8'h5A, 8'h12, 8'hED, 1, 0, 0, 8'h12, 8'h5A, 0, 2, 0, 0, 1, 0};

      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_key", int'(key), 0);
      check("rst_addr", int'(addr), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_rpt", int'(rpt), 0);
      check("rst_err", int'(err), 0);
      check("rst_w1", int'(w1), 1);
      check("rst_w2", int'(w2), 1);
      check("rst_w3", int'(w3), 1);
      check("rst_w4", int'(w4), 0);
      hold_us(1'b1, 200);

      for (int i = 0; i < 6; i++) begin
         hold_us(1'b1, vecs[i].gap_us);
         clear_counts();
         if (vecs[i].is_rpt) send_repeat();
         else send_frame({vecs[i].nc, vecs[i].c, ~vecs[i].a, vecs[i].a}, -1);
         hold_us(1'b1, 100);
         check($sformatf("v%0d_valid", i), n_valid, vecs[i].e_valid);
         check($sformatf("v%0d_rpt", i), n_rpt, vecs[i].e_rpt);
         check($sformatf("v%0d_err", i), n_err, vecs[i].e_err);
         check($sformatf("v%0d_key", i), int'(key), int'(vecs[i].e_key));
         check($sformatf("v%0d_addr", i), int'(addr), int'(vecs[i].e_addr));
         check($sformatf("v%0d_w1", i), c_w1, vecs[i].e_w1);
         check($sformatf("v%0d_w2", i), c_w2, vecs[i].e_w2);
         check($sformatf("v%0d_w3", i), c_w3, vecs[i].e_w3);
         check($sformatf("v%0d_w4", i), c_w4, vecs[i].e_w4);
         check($sformatf("v%0d_valid_addrchk", i), n_valid2, vecs[i].e_valid2);
         check($sformatf("v%0d_err_addrchk", i), n_err2, vecs[i].e_err2);
         check($sformatf("v%0d_latency", i), last_ev - rise_cyc, 4);
      end
      check("addrchk_key", int'(key2), 8'h12);
      check("addrchk_addr", int'(addr2), 8'h5A);

      // Repeat code straight after reset: window is closed.
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      check("rst2_key", int'(key), 0);
      check("rst2_addr", int'(addr), 0);
      hold_us(1'b1, 1000);
      clear_counts();
      send_repeat();
      hold_us(1'b1, 100);
      check("rstrpt_err", n_err, 1);
      check("rstrpt_rpt", n_rpt, 0);
      check("rstrpt_btn", c_w1 + c_w2 + c_w3 + c_w4, 0);
      check("rstrpt_key", int'(key), 0);

      // Short low glitch while idle.
      hold_us(1'b1, 1000);
      clear_counts();
      hold_us(1'b0, 300);
      hold_us(1'b1, 2000);
      check("glitch_pulses", n_valid + n_rpt + n_err, 0);
      check("glitch_pulses_addrchk", n_valid2 + n_err2, 0);

      // 1000 us bit space is neither a 0 nor a 1.
      clear_counts();
      hold_us(1'b0, 9000);
      hold_us(1'b1, 4500);
      for (int b = 0; b < 3; b++) begin
         hold_us(1'b0, 560);
         hold_us(1'b1, 560);
      end
      hold_us(1'b0, 560);
      hold_us(1'b1, 1000);
      hold_us(1'b0, 560);
      hold_us(1'b1, 2000);
      check("badspace_err", n_err, 1);
      check("badspace_valid", n_valid, 0);

      // Reset inside a frame, then a clean frame for SELECT.
      hold_us(1'b1, 15000);
      clear_counts();
      send_frame(32'hEE_11_FF_00, 15);
      hold_us(1'b1, 15000);
      send_frame(32'hEE_11_FF_00, -1);
      hold_us(1'b1, 100);
      check("midrst_valid", n_valid, 1);
      check("midrst_err", n_err, 0);
      check("midrst_rpt", n_rpt, 0);
      check("midrst_key", int'(key), 8'h11);
      check("midrst_w3", c_w3, 2);
      check("midrst_w1", c_w1, 0);
      check("midrst_w2", c_w2, 0);
      check("midrst_w4", c_w4, 0);
      check("midrst_latency", last_ev - rise_cyc, 4);

      check("exclusive_pulses", n_excl, 0);
      check("addrchk_rpt_total", n_rpt2, 0);
      check("addrchk_btn_total", c_btn2, 2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
